// File: rtl/sa_tg_pkg.sv
// sa_tg_pkg: shared types and constants for the systolic-array traffic generator.
//   - tg_state_e : burst sequencing states
//   - tg_mode_e  : activation pattern select (MODE_RSVD behaves as MODE_CONST)
//   - CNT_W      : width of the result_count output
//   - lfsr_taps  : maximal-length Galois tap mask for a right-shifting LFSR,
//                  bit (t-1) set for each polynomial tap t, valid for dw 4..32
package sa_tg_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } tg_state_e;

  typedef enum logic [1:0] {
    MODE_CONST = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_RSVD  = 2'd3
  } tg_mode_e;

  function automatic logic [31:0] lfsr_taps(input int dw);
    logic [31:0] m;
    case (dw)
      4:  m = 32'h0000_000C;
      5:  m = 32'h0000_0014;
      6:  m = 32'h0000_0030;
      7:  m = 32'h0000_0060;
      8:  m = 32'h0000_00B8;
      9:  m = 32'h0000_0110;
      10: m = 32'h0000_0240;
      11: m = 32'h0000_0500;
      12: m = 32'h0000_0829;
      13: m = 32'h0000_100D;
      14: m = 32'h0000_2015;
      15: m = 32'h0000_6000;
      16: m = 32'h0000_D008;
      17: m = 32'h0001_2000;
      18: m = 32'h0002_0400;
      19: m = 32'h0004_0023;
      20: m = 32'h0009_0000;
      21: m = 32'h0014_0000;
      22: m = 32'h0030_0000;
      23: m = 32'h0042_0000;
      24: m = 32'h00E1_0000;
      25: m = 32'h0120_0000;
      26: m = 32'h0200_0023;
      27: m = 32'h0400_0013;
      28: m = 32'h0900_0000;
      29: m = 32'h1400_0000;
      30: m = 32'h2000_0029;
      31: m = 32'h4800_0000;
      32: m = 32'h8020_0003;
      default: m = 32'h0000_00B8;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sa_tg_lfsr.sv
// sa_tg_lfsr: right-shifting Galois LFSR used as the pseudo-random activation
// source. Only built when SA_TG_LFSR_EN is defined.
//   clk   in  clock
//   rst   in  synchronous active-high reset; state returns to 1
//   load  in  load seed (a zero seed is replaced by 1 so the LFSR never locks up)
//   seed  in  DW-bit seed
//   adv   in  advance one step
//   value out current state
module sa_tg_lfsr
  import sa_tg_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] seed,
  input  logic          adv,
  output logic [DW-1:0] value
);

  localparam logic [31:0]   TAPS32 = lfsr_taps(DW);
  localparam logic [DW-1:0] TAPS   = TAPS32[DW-1:0];
  localparam logic [DW-1:0] ONE    = {{(DW-1){1'b0}}, 1'b1};

  logic [DW-1:0] state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ONE;
    end else if (load) begin
      state_q <= (seed == '0) ? ONE : seed;
    end else if (adv) begin
      state_q <= state_q[0] ? ((state_q >> 1) ^ TAPS) : (state_q >> 1);
    end
  end

  assign value = state_q;

endmodule

// File: rtl/sa_traffic_gen.sv
// sa_traffic_gen: start-triggered stimulus/response engine for the systolic array.
// Feeds NUM_VECTORS activation vectors (same value on every lane) with constant
// weights, drains for DRAIN_CYCLES, then pulses done. Lane results seen during
// FEED/DRAIN are counted and summed.
// Build option: SA_TG_LFSR_EN enables the LFSR pattern (mode 2); without it
// mode 2 drives the seed like mode 0.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, mode, seed   burst request and pattern select, sampled in IDLE
//   a_out, w_out        activations / weights to the core (ROWS x DW)
//   inpvalid            activation valid (high in FEED)
//   rvalid, rdata       per-lane results from the core
//   outread             result acknowledge, |rvalid delayed one cycle
//   busy, done          FEED/DRAIN indicator, one-cycle end-of-burst pulse
//   result_count        lane results accepted (wraps)
//   checksum            sum of accepted rdata mod 2^RW
//
// state   | meaning
// S_IDLE  | waiting for start, status outputs hold
// S_FEED  | driving vector i on a_out, inpvalid high
// S_DRAIN | letting the array flush, results still accumulated
// S_DONE  | one-cycle done pulse, back to IDLE
module sa_traffic_gen
  import sa_tg_pkg::*;
#(
  parameter int ROWS         = 8,
  parameter int DW           = 8,
  parameter int RW           = 32,
  parameter int NUM_VECTORS  = 16,
  parameter int DRAIN_CYCLES = 2 * ROWS * ROWS,
  parameter int W_INIT       = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [DW-1:0]            seed,
  output logic [ROWS-1:0][DW-1:0]  a_out,
  output logic [ROWS-1:0][DW-1:0]  w_out,
  output logic                     inpvalid,
  input  logic [ROWS-1:0]          rvalid,
  input  logic [ROWS-1:0][RW-1:0]  rdata,
  output logic                     outread,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         result_count,
  output logic [RW-1:0]            checksum
);

  localparam int TMR_MAX = (NUM_VECTORS > DRAIN_CYCLES) ? NUM_VECTORS : DRAIN_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] FEED_LAST  = TMR_W'(NUM_VECTORS - 1);
  localparam logic [TMR_W-1:0] DRAIN_LAST = TMR_W'(DRAIN_CYCLES - 1);
  localparam logic [DW-1:0]    W_CONST    = DW'(W_INIT);
  localparam logic [DW-1:0]    DW_ONE     = {{(DW-1){1'b0}}, 1'b1};

  tg_state_e        state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  tg_mode_e         mode_q;
  logic [DW-1:0]    seed_q;
  logic [DW-1:0]    ramp_q;
  logic [CNT_W-1:0] count_q;
  logic [RW-1:0]    sum_q;
  logic             outread_q;

  logic             start_acc;
  logic             feed;
  logic             acc_en;
  logic [CNT_W-1:0] pop;
  logic [RW-1:0]    lane_sum;
  logic [DW-1:0]    vec;

`ifdef SA_TG_LFSR_EN
  logic [DW-1:0] lfsr_value;

  sa_tg_lfsr #(.DW(DW)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (start_acc),
    .seed  (seed),
    .adv   (feed),
    .value (lfsr_value)
  );
`endif

  // Next state, timer and status outputs. The timer counts down and the
  // terminal count (zero) marks the last cycle of FEED or DRAIN.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    start_acc = 1'b0;
    feed      = 1'b0;
    inpvalid  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = S_FEED;
          tmr_d     = FEED_LAST;
        end
      end
      S_FEED: begin
        feed     = 1'b1;
        inpvalid = 1'b1;
        busy     = 1'b1;
        if (tmr_q == '0) begin
          state_d = S_DRAIN;
          tmr_d   = DRAIN_LAST;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (tmr_q == '0) begin
          state_d = S_DONE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Popcount and masked lane sum of this cycle's results.
  always_comb begin
    pop      = '0;
    lane_sum = '0;
    for (int j = 0; j < ROWS; j++) begin
      pop = pop + CNT_W'(rvalid[j]);
      if (rvalid[j]) lane_sum = lane_sum + rdata[j];
    end
  end

  assign acc_en = busy && (rvalid != '0);

  always_comb begin
    vec = seed_q;
    case (mode_q)
      MODE_RAMP: vec = ramp_q;
`ifdef SA_TG_LFSR_EN
      MODE_LFSR: vec = lfsr_value;
`else
      MODE_LFSR: vec = seed_q;
`endif
      default:   vec = seed_q;
    endcase
  end

  always_comb begin
    for (int l = 0; l < ROWS; l++) begin
      a_out[l] = inpvalid ? vec : '0;
      w_out[l] = W_CONST;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      mode_q    <= MODE_CONST;
      seed_q    <= '0;
      ramp_q    <= '0;
      count_q   <= '0;
      sum_q     <= '0;
      outread_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      outread_q <= |rvalid;
      if (start_acc) begin
        mode_q  <= tg_mode_e'(mode);
        seed_q  <= seed;
        ramp_q  <= seed;
        count_q <= '0;
        sum_q   <= '0;
      end else begin
        if (feed) ramp_q <= ramp_q + DW_ONE;
        if (acc_en) begin
          count_q <= count_q + pop;
          sum_q   <= sum_q + lane_sum;
        end
      end
    end
  end

  assign outread      = outread_q;
  assign result_count = count_q;
  assign checksum     = sum_q;

endmodule

// File: tb/tb_sa_traffic_gen.sv
// Bench for sa_traffic_gen: burst-level model compared every cycle, plus
// hand-computed expectations for ramp, const, wrap, result path, control edges
// and the LFSR option.
module tb_sa_traffic_gen;
  import sa_tg_pkg::*;

  localparam int ROWS = 8;
  localparam int DW   = 8;
  localparam int RW   = 32;
  localparam int NV   = 16;
  localparam int DC   = 2 * ROWS * ROWS;

  logic                    clk;
  logic                    rst;
  logic                    start;
  logic [1:0]              mode;
  logic [DW-1:0]           seed;
  logic [ROWS-1:0][DW-1:0] a_out;
  logic [ROWS-1:0][DW-1:0] w_out;
  logic                    inpvalid;
  logic [ROWS-1:0]         rvalid;
  logic [ROWS-1:0][RW-1:0] rdata;
  logic                    outread;
  logic                    busy;
  logic                    done;
  logic [15:0]             result_count;
  logic [RW-1:0]           checksum;

  // small DW=4 instance for ramp wrap
  logic                 start4;
  logic [1:0]           mode4;
  logic [3:0]           seed4;
  logic [1:0][3:0]      a4;
  logic [1:0][3:0]      w4;
  logic                 iv4;
  logic [1:0]           rv4;
  logic [1:0][15:0]     rd4;
  logic                 or4;
  logic                 busy4;
  logic                 done4;
  logic [15:0]          rc4;
  logic [15:0]          cs4;

  sa_traffic_gen #(.ROWS(ROWS), .DW(DW), .RW(RW), .NUM_VECTORS(NV),
                   .DRAIN_CYCLES(DC), .W_INIT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
    .a_out(a_out), .w_out(w_out), .inpvalid(inpvalid),
    .rvalid(rvalid), .rdata(rdata), .outread(outread),
    .busy(busy), .done(done), .result_count(result_count), .checksum(checksum)
  );

  sa_traffic_gen #(.ROWS(2), .DW(4), .RW(16), .NUM_VECTORS(6),
                   .DRAIN_CYCLES(2), .W_INIT(1)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode4), .seed(seed4),
    .a_out(a4), .w_out(w4), .inpvalid(iv4),
    .rvalid(rv4), .rdata(rd4), .outread(or4),
    .busy(busy4), .done(done4), .result_count(rc4), .checksum(cs4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- burst-level model ----------------
  // m_p: position within burst (-1 idle, 0..NV-1 feed, NV..NV+DC-1 drain, NV+DC done)
  int          m_p   = -1;
  logic [7:0]  m_vec [NV];
  logic [15:0] m_cnt = '0;
  logic [31:0] m_sum = '0;
  bit          m_or  = 1'b0;

  task automatic build_vec(input logic [1:0] md, input logic [7:0] sd);
    int x;
    logic [31:0] taps;
    taps = lfsr_taps(DW);
    x = (sd == 0) ? 1 : int'(sd);
    for (int i = 0; i < NV; i++) begin
      case (md)
        2'd1: m_vec[i] = 8'((int'(sd) + i) % 256);
`ifdef SA_TG_LFSR_EN
        2'd2: begin
          m_vec[i] = 8'(x);
          x = (x % 2 == 1) ? ((x >> 1) ^ int'(taps[7:0])) : (x >> 1);
        end
`endif
        default: m_vec[i] = sd;
      endcase
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_p = -1; m_cnt = '0; m_sum = '0; m_or = 1'b0;
    end else begin
      m_or = (rvalid != '0);
      if (m_p >= 0 && m_p < NV + DC) begin
        for (int j = 0; j < ROWS; j++)
          if (rvalid[j]) begin
            m_cnt = m_cnt + 16'd1;
            m_sum = m_sum + rdata[j];
          end
      end
      if (m_p == -1) begin
        if (start) begin
          m_p = 0; m_cnt = '0; m_sum = '0;
          build_vec(mode, seed);
        end
      end else if (m_p == NV + DC) m_p = -1;
      else m_p++;
    end
  end

  always @(posedge clk) begin
    logic [63:0] exp_a;
    logic [7:0]  v;
    #1;
    v = (m_p >= 0 && m_p < NV) ? m_vec[m_p] : 8'h00;
    exp_a = {8{v}};
    chk("inpvalid", inpvalid, (m_p >= 0 && m_p < NV));
    chk("busy", busy, (m_p >= 0 && m_p < NV + DC));
    chk("done", done, (m_p == NV + DC));
    chk("outread", outread, m_or);
    chk("result_count", result_count, m_cnt);
    chk("checksum", checksum, m_sum);
    chk("a_out", a_out, exp_a);
    chk("w_out", w_out, 64'h0101_0101_0101_0101);
  end

  // ---------------- directed stimulus ----------------
  int          g_busy_n, g_iv_n, g_done_n;
  logic [7:0]  g_vec [NV];
  bit          g_or1, g_or2;
  logic [15:0] g_cnt;
  logic [31:0] g_sum;

  task automatic run_burst(input logic [1:0] m, input logic [7:0] s,
                           input int restart_at, input int rv_at);
    bit seen;
    g_busy_n = 0; g_iv_n = 0; g_done_n = 0; g_or1 = 0; g_or2 = 0; seen = 0;
    g_cnt = '0; g_sum = '0;
    @(negedge clk); start = 1'b1; mode = m; seed = s;
    @(negedge clk); start = 1'b0;
    for (int p = 0; p < 400 && !seen; p++) begin
      if (busy) g_busy_n++;
      if (inpvalid) begin
        if (g_iv_n < NV) g_vec[g_iv_n] = a_out[0];
        g_iv_n++;
      end
      if (p == rv_at + 1) g_or1 = outread;
      if (p == rv_at + 2) g_or2 = outread;
      if (done) begin
        g_done_n++; seen = 1;
        g_cnt = result_count; g_sum = checksum;
      end
      start    = (p == restart_at);
      rvalid   = (p == rv_at) ? 8'b0000_0011 : 8'h00;
      rdata[0] = (p == rv_at) ? 32'd10 : 32'd0;
      rdata[1] = (p == rv_at) ? 32'd20 : 32'd0;
      @(negedge clk);
    end
    if (!seen) chk("burst_timeout", 64'd0, 64'd1);
    start = 1'b0; rvalid = '0; rdata = '0;
    if (done) g_done_n++;
  endtask

  initial begin
    bit distinct;
    logic [3:0] v4 [6];
    int n4;
    rst = 1'b1; start = 1'b0; mode = 2'd0; seed = '0; rvalid = '0; rdata = '0;
    start4 = 1'b0; mode4 = 2'd0; seed4 = '0; rv4 = '0; rd4 = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_a_out", a_out, 0);
    chk("reset_w_out", w_out, 64'h0101_0101_0101_0101);
    rst = 1'b0;

    // ramp burst
    run_burst(2'd1, 8'd0, -1, -1);
    chk("ramp_busy_cycles", g_busy_n, 144);
    chk("ramp_inpvalid_cycles", g_iv_n, 16);
    chk("ramp_done_pulses", g_done_n, 1);
    for (int i = 0; i < NV; i++) chk("ramp_vec", g_vec[i], i);

    // const and reserved mode
    run_burst(2'd0, 8'd5, -1, -1);
    chk("const_vec0", g_vec[0], 5);
    chk("const_vec15", g_vec[15], 5);
    run_burst(2'd3, 8'h5A, -1, -1);
    chk("rsvd_vec9", g_vec[9], 8'h5A);

    // result path in DRAIN
    run_burst(2'd1, 8'd0, -1, NV + 10);
    chk("outread_next", g_or1, 1);
    chk("outread_after", g_or2, 0);
    chk("done_count", g_cnt, 2);
    chk("done_checksum", g_sum, 30);

    // same pulse in IDLE: counters hold
    @(negedge clk); rvalid = 8'b0000_0011; rdata[0] = 32'd10; rdata[1] = 32'd20;
    @(negedge clk); rvalid = '0; rdata = '0;
    @(negedge clk);
    chk("idle_count_hold", result_count, 2);
    chk("idle_sum_hold", checksum, 30);

    // start inside FEED ignored
    run_burst(2'd1, 8'd0, 3, -1);
    chk("restart_busy_cycles", g_busy_n, 144);
    chk("restart_done_pulses", g_done_n, 1);
    chk("restart_vec4", g_vec[4], 4);

    // reset mid-burst
    @(negedge clk); start = 1'b1; mode = 2'd1; seed = 8'd0;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    rvalid = 8'h01; rdata[0] = 32'd7;
    @(negedge clk); rvalid = '0; rdata = '0;
    @(negedge clk);
    chk("pre_rst_count", result_count, 1);
    chk("pre_rst_sum", checksum, 7);
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk); rst = 1'b0; start = 1'b0;
    chk("rst_inpvalid", inpvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", result_count, 0);
    chk("rst_sum", checksum, 0);
    chk("rst_a_out", a_out, 0);
    @(negedge clk);
    chk("rst_start_lost", busy, 0);
    run_burst(2'd1, 8'd3, -1, -1);
    chk("post_rst_busy_cycles", g_busy_n, 144);
    chk("post_rst_vec2", g_vec[2], 5);

    // LFSR mode, seed 0
    run_burst(2'd2, 8'd0, -1, -1);
`ifdef SA_TG_LFSR_EN
    chk("lfsr_vec0", g_vec[0], 1);
    chk("lfsr_vec1", g_vec[1], 8'hB8);
    chk("lfsr_vec2", g_vec[2], 8'h5C);
    distinct = 1;
    for (int i = 0; i < NV; i++)
      for (int k = i + 1; k < NV; k++)
        if (g_vec[i] == g_vec[k]) distinct = 0;
    chk("lfsr_distinct", distinct, 1);
`else
    chk("lfsr_off_vec0", g_vec[0], 0);
    chk("lfsr_off_vec15", g_vec[15], 0);
`endif

    // DW=4 ramp wrap
    @(negedge clk); start4 = 1'b1; mode4 = 2'd1; seed4 = 4'd14;
    @(negedge clk); start4 = 1'b0;
    n4 = 0;
    for (int p = 0; p < 40 && !done4; p++) begin
      if (iv4 && n4 < 6) begin
        v4[n4] = a4[0];
        chk("dw4_lane_match", a4[1], a4[0]);
        n4++;
      end
      @(negedge clk);
    end
    chk("dw4_vec_count", n4, 6);
    chk("dw4_v0", v4[0], 14);
    chk("dw4_v1", v4[1], 15);
    chk("dw4_v2", v4[2], 0);
    chk("dw4_v3", v4[3], 1);
    chk("dw4_v5", v4[5], 3);
    chk("dw4_done", done4, 1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
